// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Handshaked on both sides; flags overflow (optionally saturating to all 9s)
// and reports a leading-zero blank mask for the display path.
//
// state | meaning
// IDLE  | waiting for a value, in_ready high
// CONV  | shifting one binary bit per cycle into the BCD accumulator
// DONE  | result presented with out_valid, held until out_ready
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int SAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest representable decimal value; the compare is wide enough for both operands.
  localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;
  localparam int DEC_W = $clog2(pow10(DIGITS));
  localparam int CMP_W = (BIN_W > DEC_W) ? BIN_W : DEC_W;
  localparam logic [CMP_W-1:0] MAX_CMP = MAX_DEC[CMP_W-1:0];
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      shift_q, shift_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [DIGITS-1:0]     blank_q, blank_d;

  logic [CMP_W-1:0]      bin_ext;
  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_shift;
  logic [4*DIGITS-1:0]   res_bcd;
  logic [DIGITS-1:0]     res_blank;
  logic                  hi_zero;

  assign bin_ext   = CMP_W'(bin_in);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;
  assign blank     = blank_q;

  // One double-dabble step: correct digits >= 5, then shift the next binary bit in.
  // The carry out of the top digit is dropped, which leaves the value mod 10^DIGITS.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = (4*DIGITS)'({acc_adj, shift_q[BIN_W-1]});
  end

  // Final result selection and leading-zero mask; digit 0 is never blanked.
  always_comb begin
    res_bcd   = ((SAT != 0) && ovf_pend_q) ? {DIGITS{4'h9}} : acc_shift;
    res_blank = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero && (res_bcd[4*i +: 4] == 4'd0);
      res_blank[i] = hi_zero;
    end
  end

  // Next-state and datapath updates for the converter FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    blank_d    = blank_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d    = bin_in;
          acc_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (bin_ext > MAX_CMP);
          state_d    = CONV;
        end
      end
      CONV: begin
        shift_d = shift_q << 1;
        acc_d   = acc_shift;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = res_bcd;
          ovf_d   = ovf_pend_q;
          blank_d = res_blank;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      blank_q    <= blank_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a decimal-arithmetic model with a per-cycle compare,
// directed vectors with literal expectations, and a randomised back-to-back sweep.
module tb_bin2bcd_seq;
  localparam int BW = 14;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [BW-1:0]   bin_in = '0;
  logic            in_ready, out_valid, ovf;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   blank;
  logic            m_in_ready, m_out_valid, m_ovf;
  logic [4*ND-1:0] m_bcd_out;
  logic [ND-1:0]   m_blank_out;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready, s_out_valid, s_ovf;
  logic [5:0] s_bin = '0;
  logic [7:0] s_bcd;
  logic [1:0] s_blank;

  bin2bcd_seq #(.BIN_W(BW), .DIGITS(ND), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .ovf(ovf), .blank(blank));

  bin2bcd_seq #(.BIN_W(BW), .DIGITS(ND), .SAT(0)) u_mod (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready), .bin_in(bin_in),
    .out_valid(m_out_valid), .out_ready(out_ready), .bcd_out(m_bcd_out), .ovf(m_ovf),
    .blank(m_blank_out));

  bin2bcd_seq #(.BIN_W(6), .DIGITS(2), .SAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .bin_in(s_bin),
    .out_valid(s_out_valid), .out_ready(1'b1), .bcd_out(s_bcd), .ovf(s_ovf), .blank(s_blank));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4*ND-1:0] m_bcd(input int v, input bit sat);
    longint lim, x;
    logic [4*ND-1:0] r;
    lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * 10;
    x = v;
    if (x >= lim) x = sat ? lim - 1 : x % lim;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [ND-1:0] m_blank(input logic [4*ND-1:0] b);
    logic [ND-1:0] r;
    r = '0;
    for (int i = 1; i < ND; i++) r[i] = ((b >> (4*i)) == '0);
    return r;
  endfunction

  function automatic bit m_legal(input logic [4*ND-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < ND; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  typedef struct {int v; int k;} txn_t;
  txn_t q[$];
  int   ecnt = 0;
  int   n_hs = 0;

  // Model: one outstanding transaction, result due BW edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (q.size() == 0) begin
        if (in_valid) q.push_back('{int'(bin_in), ecnt + 1});
      end else if (out_ready && (ecnt >= q[0].k + BW)) begin
        void'(q.pop_front());
      end
      if (out_valid && out_ready) n_hs++;
      ecnt++;
    end
  end

  bit busy, ev;
  int cur_v;

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      busy = (q.size() != 0);
      ev = busy ? (ecnt >= q[0].k + BW) : 1'b0;
      chk("in_ready", in_ready, !busy);
      chk("mod_in_ready", m_in_ready, !busy);
      chk("out_valid", out_valid, ev);
      chk("mod_out_valid", m_out_valid, ev);
      chk("bcd_legal", m_legal(bcd_out) && m_legal(m_bcd_out), 1);
      if (ev) begin
        cur_v = q[0].v;
        chk("bcd_out", bcd_out, m_bcd(cur_v, 1'b1));
        chk("ovf", ovf, cur_v > 9999);
        chk("blank", blank, m_blank(m_bcd(cur_v, 1'b1)));
        chk("mod_bcd_out", m_bcd_out, m_bcd(cur_v, 1'b0));
        chk("mod_ovf", m_ovf, cur_v > 9999);
        chk("mod_blank", m_blank_out, m_blank(m_bcd(cur_v, 1'b0)));
      end
    end
  end

  int acc_k;
  int cap_lat;
  logic [4*ND-1:0] cap_bcd, cap_mbcd;
  logic cap_ovf;
  logic [ND-1:0] cap_blank;

  task automatic send(input int v);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    bin_in = BW'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 acc_k = ecnt;
    @(negedge clk);
    in_valid = 1'b0;
    bin_in = BW'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("valid_timeout", 1, 0);
    cap_lat   = ecnt - acc_k;
    cap_bcd   = bcd_out;
    cap_mbcd  = m_bcd_out;
    cap_ovf   = ovf;
    cap_blank = blank;
  endtask

  task automatic run_one(input int v);
    out_ready = 1'b1;
    send(v);
    wait_valid();
    @(negedge clk);
  endtask

  int vals[13] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 10001, 16383};
  bit sweep_on = 1'b0;
  int n_sent, hs0, n;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_blank", blank, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("pin_305", m_bcd(305, 1'b1), 16'h0305);
    chk("pin_sat", m_bcd(12345, 1'b1), 16'h9999);
    chk("pin_mod", m_bcd(12345, 1'b0), 16'h2345);
    chk("pin_blank0", m_blank(16'h0000), 4'b1110);
    chk("pin_blank305", m_blank(16'h0305), 4'b1000);

    // Narrow instance: 6-bit input, 2 digits.
    s_bin = 6'd59;
    s_in_valid = 1'b1;
    @(posedge clk);
    #1 acc_k = ecnt;
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("small_lat", ecnt - acc_k, 6);
    chk("small_bcd", s_bcd, 8'h59);
    chk("small_ovf", s_ovf, 0);
    chk("small_blank", s_blank, 2'b00);
    @(negedge clk);

    run_one(9999);
    chk("d9999_bcd", cap_bcd, 16'h9999);
    chk("d9999_ovf", cap_ovf, 0);
    chk("d9999_lat", cap_lat, BW);
    run_one(0);
    chk("d0_bcd", cap_bcd, 16'h0000);
    chk("d0_blank", cap_blank, 4'b1110);
    run_one(7);
    chk("d7_bcd", cap_bcd, 16'h0007);
    chk("d7_blank", cap_blank, 4'b1110);
    run_one(305);
    chk("d305_bcd", cap_bcd, 16'h0305);
    chk("d305_blank", cap_blank, 4'b1000);

    // Backpressure: result held, new input ignored.
    out_ready = 1'b0;
    send(1234);
    wait_valid();
    chk("bp_lat", cap_lat, BW);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      bin_in = BW'(55);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", bcd_out, 16'h1234);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    run_one(55);
    chk("bp_next_bcd", cap_bcd, 16'h0055);

    run_one(12345);
    chk("sat_bcd", cap_bcd, 16'h9999);
    chk("sat_ovf", cap_ovf, 1);
    chk("mod_bcd", cap_mbcd, 16'h2345);

    // Reset in the middle of a conversion.
    send(9876);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_bcd", bcd_out, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_blank", blank, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    run_one(4321);
    chk("post_rst_bcd", cap_bcd, 16'h4321);
    chk("post_rst_ovf", cap_ovf, 0);
    chk("post_rst_lat", cap_lat, BW);

    // Back-to-back sweep with random backpressure.
    hs0 = n_hs;
    n_sent = 0;
    sweep_on = 1'b1;
    fork
      begin
        while (sweep_on) begin
          @(negedge clk);
          if (sweep_on) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 13; i++) begin
      send(vals[i]);
      n_sent++;
    end
    for (int i = 0; i < 120; i++) begin
      send(int'($urandom_range(0, 16383)));
      n_sent++;
    end
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
    sweep_on = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("sweep_count", n_hs - hs0, n_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
